// File: rtl/return_stack_ctrl_pkg.sv
// Shared controller definitions: {C,Z} flag field layout and default PC width.
package return_stack_ctrl_pkg;

    localparam int unsigned FLAG_W         = 2;
    localparam int unsigned FLAG_C         = 1;
    localparam int unsigned FLAG_Z         = 0;
    localparam int unsigned DEFAULT_ADDR_W = 12;

    // Operation decoded from the push/pop request pair and the current fill level.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_PUSH_FULL,
        OP_POP,
        OP_POP_EMPTY,
        OP_REPLACE
    } stack_op_e;

endpackage

// File: rtl/return_stack_ctrl.sv
// Subroutine return stack: circular buffer of {address, C/Z flags} entries with
// top pointer + count, sticky overflow/underflow flags and single-cycle push/pop.
module return_stack_ctrl
    import return_stack_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH    = 8,
    parameter bit          OVF_WRAP = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [FLAG_W-1:0]            push_flags,
    output logic [ADDR_W-1:0]            top_addr,
    output logic [FLAG_W-1:0]            top_flags,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clear
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [FLAG_W-1:0] flags;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            mem_we;
    logic [PW-1:0]   mem_waddr;
    entry_t          mem_wdata;
    logic            ovf_set, unf_set;
    stack_op_e       op;
    entry_t          top_entry;

    logic            is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Classify the request; the simultaneous push+pop on an empty stack degrades to a push.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = is_empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = is_full ? OP_PUSH_FULL : OP_PUSH;
        end else if (pop) begin
            op = is_empty ? OP_POP_EMPTY : OP_POP;
        end
    end

    // Next-state pointer/count, entry write port and error-flag updates.
    always_comb begin
        top_d     = top_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = top_q + 1'b1;
        mem_wdata = '{addr: push_addr, flags: push_flags};
        ovf_set   = 1'b0;
        unf_set   = push && pop && is_empty;

        unique case (op)
            OP_PUSH: begin
                mem_we  = 1'b1;
                top_d   = top_q + 1'b1;
                count_d = count_q + 1'b1;
            end
            OP_PUSH_FULL: begin
                ovf_set = 1'b1;
                if (OVF_WRAP) begin
                    mem_we = 1'b1;
                    top_d  = top_q + 1'b1;
                end
            end
            OP_POP: begin
                top_d   = top_q - 1'b1;
                count_d = count_q - 1'b1;
            end
            OP_POP_EMPTY: begin
                unf_set = 1'b1;
            end
            OP_REPLACE: begin
                mem_we    = 1'b1;
                mem_waddr = top_q;
            end
            default: begin
            end
        endcase

        // A new error event in the same cycle as err_clear takes priority.
        ovf_d = ovf_set | (ovf_q & ~err_clear);
        unf_d = unf_set | (unf_q & ~err_clear);
    end

    // Control state: asynchronously cleared, storage contents are left alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry array write port; an empty stack masks stale contents on the outputs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign top_entry = mem_q[top_q];
    assign top_addr  = is_empty ? '0 : top_entry.addr;
    assign top_flags = is_empty ? '0 : top_entry.flags;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Directed bench: two DEPTH=4/ADDR_W=8 instances (reject vs wrap on overflow) share stimulus.
module tb_return_stack_ctrl;
    import return_stack_ctrl_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0, pop = 1'b0, err_clear = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic [1:0]    push_flags = '0;

    logic [AW-1:0] ta0, ta1;
    logic [1:0]    tf0, tf1;
    logic [CW-1:0] cnt0, cnt1;
    logic          emp0, emp1, ful0, ful1, ovf0, ovf1, unf0, unf1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    return_stack_ctrl #(.ADDR_W(AW), .DEPTH(DP), .OVF_WRAP(1'b0)) u_rej (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_addr(push_addr), .push_flags(push_flags),
        .top_addr(ta0), .top_flags(tf0), .count(cnt0), .empty(emp0), .full(ful0),
        .overflow(ovf0), .underflow(unf0), .err_clear(err_clear)
    );

    return_stack_ctrl #(.ADDR_W(AW), .DEPTH(DP), .OVF_WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_addr(push_addr), .push_flags(push_flags),
        .top_addr(ta1), .top_flags(tf1), .count(cnt1), .empty(emp1), .full(ful1),
        .overflow(ovf1), .underflow(unf1), .err_clear(err_clear)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one request for one clock edge, then return inputs to idle #1 after the edge.
    task automatic step(input logic pu, input logic po, input logic [AW-1:0] a,
                        input logic [1:0] f, input logic clr);
        push = pu; pop = po; push_addr = a; push_flags = f; err_clear = clr;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clear = 1'b0; push_addr = '0; push_flags = '0;
    endtask

    task automatic check_both(input string tag, input int c, input logic [AW-1:0] t,
                              input logic o, input logic u);
        check_eq({tag, " rej count"}, 32'(cnt0), 32'(c));
        check_eq({tag, " rej top"},   32'(ta0),  32'(t));
        check_eq({tag, " rej ovf"},   32'(ovf0), 32'(o));
        check_eq({tag, " rej unf"},   32'(unf0), 32'(u));
        check_eq({tag, " wrap count"}, 32'(cnt1), 32'(c));
        check_eq({tag, " wrap top"},   32'(ta1),  32'(t));
        check_eq({tag, " wrap ovf"},   32'(ovf1), 32'(o));
        check_eq({tag, " wrap unf"},   32'(unf1), 32'(u));
    endtask

    logic [AW-1:0] exp_rej  [4];
    logic [AW-1:0] exp_wrap [4];
    logic [AW-1:0] lifo     [3];

    initial begin
        exp_rej  = '{8'h99, 8'hA3, 8'hA2, 8'hA1};
        exp_wrap = '{8'h55, 8'h99, 8'hA3, 8'hA2};
        lifo     = '{8'h33, 8'h22, 8'h11};

        // Reset state while held low
        #2;
        check_both("reset", 0, 8'h00, 1'b0, 1'b0);
        check_eq("reset empty", 32'(emp0), 32'd1);
        check_eq("reset full",  32'(ful0), 32'd0);
        check_eq("reset flags", 32'(tf0),  32'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // LIFO order: push 11,22,33 then pop x3
        step(1, 0, 8'h11, 2'b00, 0);
        check_both("push1", 1, 8'h11, 0, 0);
        step(1, 0, 8'h22, 2'b00, 0);
        check_both("push2", 2, 8'h22, 0, 0);
        step(1, 0, 8'h33, 2'b00, 0);
        check_both("push3", 3, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("pop%0d value", i), 32'(ta0), 32'(lifo[i]));
            step(0, 1, 8'h00, 2'b00, 0);
            check_eq($sformatf("pop%0d count", i), 32'(cnt0), 32'(2 - i));
        end
        check_eq("lifo empty", 32'(emp0), 32'd1);
        check_eq("lifo empty top", 32'(ta0), 32'd0);

        // Flags travel with the address and are visible in the pop cycle
        step(1, 0, 8'h12, 2'b10, 0);
        pop = 1'b1;
        check_eq("flags in pop cycle", 32'(tf0), 32'd2);
        check_eq("flags wrap inst", 32'(tf1), 32'd2);
        step(0, 1, 8'h00, 2'b00, 0);
        check_eq("flags after pop", 32'(tf0), 32'd0);

        // Fill, replace at full, then overflow push
        step(1, 0, 8'hA1, 2'b00, 0);
        step(1, 0, 8'hA2, 2'b00, 0);
        step(1, 0, 8'hA3, 2'b00, 0);
        step(1, 0, 8'hA4, 2'b00, 0);
        check_both("fill", 4, 8'hA4, 0, 0);
        check_eq("fill full", 32'(ful0), 32'd1);
        step(1, 1, 8'h99, 2'b00, 0);
        check_both("replace full", 4, 8'h99, 0, 0);
        step(1, 0, 8'h55, 2'b00, 0);
        check_eq("ovf rej count", 32'(cnt0), 32'd4);
        check_eq("ovf rej top",   32'(ta0),  32'h99);
        check_eq("ovf rej flag",  32'(ovf0), 32'd1);
        check_eq("ovf wrap count", 32'(cnt1), 32'd4);
        check_eq("ovf wrap top",   32'(ta1),  32'h55);
        check_eq("ovf wrap flag",  32'(ovf1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d rej", i),  32'(ta0), 32'(exp_rej[i]));
            check_eq($sformatf("drain%0d wrap", i), 32'(ta1), 32'(exp_wrap[i]));
            step(0, 1, 8'h00, 2'b00, 0);
        end
        check_both("drained", 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 2'b00, 1);
        check_both("ovf cleared", 0, 8'h00, 0, 0);

        // Underflow, clear, and err_clear colliding with a new underflow
        step(0, 1, 8'h00, 2'b00, 0);
        check_both("underflow", 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 2'b00, 0);
        check_eq("unf sticky", 32'(unf0), 32'd1);
        step(0, 0, 8'h00, 2'b00, 1);
        check_both("unf cleared", 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 2'b00, 1);
        check_eq("clear vs new unf", 32'(unf0), 32'd1);
        step(0, 0, 8'h00, 2'b00, 1);

        // Simultaneous push+pop: replace when non-empty, push+underflow when empty
        step(1, 0, 8'h11, 2'b00, 0);
        step(1, 0, 8'h22, 2'b00, 0);
        step(1, 1, 8'h77, 2'b01, 0);
        check_both("replace", 2, 8'h77, 0, 0);
        check_eq("replace flags", 32'(tf0), 32'd1);
        step(0, 1, 8'h00, 2'b00, 0);
        check_eq("under replace", 32'(ta0), 32'h11);
        step(0, 1, 8'h00, 2'b00, 0);
        step(1, 1, 8'h44, 2'b00, 0);
        check_both("pushpop empty", 1, 8'h44, 0, 1);
        step(0, 1, 8'h00, 2'b00, 1);

        // Asynchronous reset mid-operation
        step(1, 0, 8'h01, 2'b00, 0);
        step(1, 0, 8'h02, 2'b00, 0);
        step(1, 0, 8'h03, 2'b00, 0);
        check_eq("pre-reset count", 32'(cnt0), 32'd3);
        #2 reset = 1'b0;
        #1;
        check_both("async reset", 0, 8'h00, 0, 0);
        check_eq("async reset empty", 32'(emp1), 32'd1);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 8'h66, 2'b00, 0);
        check_both("post-reset push", 1, 8'h66, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/return_stack_ctrl.md
RETURN_STACK_CTRL -- requirements
Module: return_stack_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning return-address (PC) width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries (power of two, at least 2).
REQ-003 The block SHALL have parameter OVF_WRAP, default 0, meaning 0 = reject push when full, 1 = overwrite oldest entry when full.
REQ-004 The block SHALL have the following port list (CW = $clog2(DEPTH+1)):
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  push request (JSB).
- pop  input  1  pop request (RET).
- push_addr  input  ADDR_W  return address to save.
- push_flags  input  2  {C,Z} to save with the address.
- top_addr  output  ADDR_W  address in the top entry; 0 when empty.
- top_flags  output  2  flags in the top entry; 0 when empty.
- count  output  CW  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky error flag: push while full.
- underflow  output  1  sticky error flag: pop while empty.
- err_clear  input  1  clears both sticky error flags.

Function
REQ-005 Storage SHALL be a circular buffer of DEPTH entries, each entry {ADDR_W address, 2 flags}, indexed by a top pointer plus count.
REQ-006 top_addr, top_flags, empty and full SHALL be derived combinationally from registered state only, never from push or pop in the same cycle.
REQ-007 Pop semantics:
- the value popped is the top_addr/top_flags value present in the cycle pop is asserted;
- the next entry becomes visible after the rising edge.
REQ-008 Push only, not full: the block SHALL write the entry at top+1 (mod DEPTH), advance top and increment count; the new top SHALL be visible the cycle after the edge.
REQ-009 Pop only, not empty: the block SHALL decrement top (mod DEPTH) and count; stored data SHALL be left unchanged.
REQ-010 Push and pop together, not empty: the block SHALL overwrite the top entry in place; count and top SHALL be unchanged; neither error flag SHALL be set, even when full.
REQ-011 Push and pop together, empty: the block SHALL act as push only (count becomes 1) and SHALL set underflow.
REQ-012 Push only, full, OVF_WRAP=0: the block SHALL drop the push, leave the state unchanged and set overflow.
REQ-013 Push only, full, OVF_WRAP=1: the block SHALL write at top+1, overwriting the oldest entry, advance top, keep count at DEPTH and set overflow.
REQ-014 Pop only, empty: the block SHALL leave the state unchanged and set underflow.
REQ-015 overflow and underflow SHALL hold until err_clear; when err_clear and a new error event occur in the same cycle, the new error SHALL win (flag reads 1 after the edge).
REQ-016 count SHALL never exceed DEPTH or go below 0; pointer arithmetic SHALL be modulo DEPTH with no out-of-range index.
REQ-017 Latency from a push/pop request to the updated outputs SHALL be exactly one clock edge; there SHALL be no stall or handshake (single-cycle acceptance).

Reset
REQ-018 While reset=0, asynchronously: count=0, top pointer=0, overflow=0, underflow=0, so empty=1, full=0, top_addr=0, top_flags=0.
REQ-019 Entry storage need not be cleared on reset; an empty stack SHALL mask it to zero on the outputs.
REQ-020 Reset asserted mid-operation SHALL discard all entries immediately; the first push after release SHALL land at count=1.

Structure
REQ-021 The {C,Z} flag-field width (2), the flag bit order (C=bit1, Z=bit0) and the default ADDR_W SHALL live in the shared controller package, shared with the Controller and BranchController.
REQ-022 No sub-module is required; the entry array SHALL be a single register array inside return_stack_ctrl.

Verification (DEPTH=4, ADDR_W=8)
REQ-023 Push 0x11, 0x22, 0x33, then pop x3 -> popped 0x33, 0x22, 0x11; count 3,2,1,0; empty=1 at the end.
REQ-024 Fill to 4 entries, push 0x55 with OVF_WRAP=0 -> count=4, top_addr unchanged, overflow=1; same with OVF_WRAP=1 -> top_addr=0x55, oldest entry lost, four pops return 0x55 and the three newest entries.
REQ-025 Pop when empty -> underflow=1, count=0, top_addr=0; err_clear next cycle -> underflow=0.
REQ-026 With 2 entries (top 0x22), push 0x77 + pop in the same cycle -> count=2, top_addr=0x77; when empty, push 0x44 + pop -> count=1, top_addr=0x44, underflow=1.
REQ-027 Push 3 entries, assert reset=0 between edges -> count=0, empty=1 immediately; after release, push 0x66 -> count=1, top_addr=0x66.
REQ-028 With flags 2'b10 pushed with 0x12, pop -> top_flags=2'b10 in the pop cycle.
